// File: rtl/ghr_ckpt_ctrl.sv
// ghr_ckpt_ctrl
//   Sequences the perceptron predictor's global-history shift register.
//   Each accepted prediction shifts the history speculatively and saves the
//   pre-shift history in a checkpoint FIFO (one entry per in-flight branch).
//   Branches resolve in order. On a mispredict the history is rebuilt from the
//   oldest checkpoint plus the actual outcome. It is then parallel-loaded into
//   the shift register during a single RESTORE cycle.
//
// Parameters
//   HIST_LEN  shift register width (>= 2)
//   NUM_CKPT  checkpoint FIFO depth (power of 2, >= 2)
//
// Ports
//   clk_i, rst_ni                  clock, async active-low reset
//   flush_i                        drop all checkpoints, cancel a restore
//   pred_valid_i/pred_taken_i      prediction request and direction
//   pred_ready_o/pred_tag_o        accept strobe and FIFO slot of the accept
//   res_valid_i/res_mispredict_i/res_taken_i  in-order resolution of oldest
//   ghr_i                          current shift register contents
//   sr_we_o/sr_data_o              parallel load to the shift register
//   sr_se_o/sr_shift_in_o          shift enable and shifted-in bit
//   inflight_o                     occupied checkpoints
//   mispred_cnt_o                  saturating mispredict count
//
// Optional feature macro: GHR_MISPRED_CNT_EN
//   defined   -> mispred_cnt_o counts mispredicts that enter RESTORE
//   undefined -> mispred_cnt_o is tied to 0
//
// States
//   RUN     | normal operation: accept predictions, pop on resolve
//   RESTORE | one cycle: parallel-load the rebuilt history, block predictions

module ghr_ckpt_ctrl #(
  parameter int HIST_LEN = 32,
  parameter int NUM_CKPT = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          pred_valid_i,
  input  logic                          pred_taken_i,
  output logic                          pred_ready_o,
  output logic [$clog2(NUM_CKPT)-1:0]   pred_tag_o,
  input  logic                          res_valid_i,
  input  logic                          res_mispredict_i,
  input  logic                          res_taken_i,
  input  logic [HIST_LEN-1:0]           ghr_i,
  output logic                          sr_we_o,
  output logic                          sr_se_o,
  output logic                          sr_shift_in_o,
  output logic [HIST_LEN-1:0]           sr_data_o,
  output logic [$clog2(NUM_CKPT):0]     inflight_o,
  output logic [31:0]                   mispred_cnt_o
);

  localparam int TAG_W = $clog2(NUM_CKPT);
  localparam int CNT_W = TAG_W + 1;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_RESTORE = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  // The MSB of a checkpoint is shifted out by the restore, so it is not kept.
  logic [HIST_LEN-2:0] r_ckpt [NUM_CKPT];
  logic                w_unused_ghr_msb;

  logic [TAG_W-1:0]    r_wr_ptr;
  logic [TAG_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_inflight;
  logic [HIST_LEN-1:0] r_restore;

  logic                w_full;
  logic                w_empty;
  logic                w_res_mis;
  logic                w_mis_take;
  logic                w_res_ok;
  logic                w_accept;
  logic                w_ready;

  assign w_unused_ghr_msb = ghr_i[HIST_LEN-1];

  // Full/empty come from the occupancy count; pointers alone are ambiguous
  // once they wrap.
  assign w_full    = (r_inflight == CNT_W'(NUM_CKPT));
  assign w_empty   = (r_inflight == '0);
  assign w_res_mis = res_valid_i & res_mispredict_i;

  // A mispredict only counts when there is a checkpoint to rebuild from.
  assign w_mis_take = w_res_mis & ~w_empty & ~flush_i & (r_state == ST_RUN);
  assign w_res_ok   = res_valid_i & ~res_mispredict_i & ~w_empty & ~flush_i;
  assign w_accept   = pred_valid_i & w_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and shift-register controls
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_ready       = 1'b0;
    sr_we_o       = 1'b0;
    sr_se_o       = 1'b0;
    sr_shift_in_o = 1'b0;

    case (r_state)
      ST_RUN: begin
        // No bypass: a full FIFO blocks even if a pop happens this cycle.
        w_ready = ~w_full & ~flush_i & ~w_res_mis;
        sr_se_o = pred_valid_i & w_ready;
        sr_shift_in_o = pred_valid_i & w_ready & pred_taken_i;
        if (w_mis_take) begin
          w_state_nxt = ST_RESTORE;
        end
      end
      ST_RESTORE: begin
        sr_we_o     = ~flush_i;
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase

    if (flush_i) begin
      w_state_nxt = ST_RUN;
    end
  end

  assign pred_ready_o = w_ready;
  assign pred_tag_o   = r_wr_ptr;
  assign inflight_o   = r_inflight;
  assign sr_data_o    = r_restore;

  // ---------------------------------------------------------------------------
  // Checkpoint storage (data only, no reset needed)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_ckpt[r_wr_ptr] <= ghr_i[HIST_LEN-2:0];
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers, occupancy and restore value
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_inflight <= '0;
      r_restore  <= '0;
    end else if (flush_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_inflight <= '0;
    end else if (w_mis_take) begin
      // Younger branches are squashed upstream, so the whole FIFO goes.
      r_restore  <= {r_ckpt[r_rd_ptr], res_taken_i};
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_inflight <= '0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + TAG_W'(1);
      end
      if (w_res_ok) begin
        r_rd_ptr <= r_rd_ptr + TAG_W'(1);
      end
      case ({w_accept, w_res_ok})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Optional mispredict counter
  // ---------------------------------------------------------------------------
`ifdef GHR_MISPRED_CNT_EN
  logic [31:0] r_mispred_cnt;

  // Flush cannot coincide with w_mis_take, so the count ignores flushes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mispred_cnt <= '0;
    end else if (w_mis_take && (r_mispred_cnt != 32'hFFFF_FFFF)) begin
      r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

  assign mispred_cnt_o = r_mispred_cnt;
`else
  assign mispred_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_ghr_ckpt_ctrl.sv
module tb_ghr_ckpt_ctrl;

  localparam int HL = 8;
  localparam int NC = 4;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          pv, pt;
  logic          ready;
  logic [1:0]    tag;
  logic          rv, rm, rt;
  logic [HL-1:0] ghr;
  logic          we, se, sin;
  logic [HL-1:0] sdata;
  logic [2:0]    inflight;
  logic [31:0]   mcnt;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [HL-1:0] m_q[$];
  bit            m_rest;
  logic [HL-1:0] m_rval;
  logic [HL-1:0] m_ghr;
  int            m_wr;
  logic [31:0]   m_cnt;

  ghr_ckpt_ctrl #(.HIST_LEN(HL), .NUM_CKPT(NC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .pred_valid_i(pv), .pred_taken_i(pt),
    .pred_ready_o(ready), .pred_tag_o(tag),
    .res_valid_i(rv), .res_mispredict_i(rm), .res_taken_i(rt),
    .ghr_i(ghr),
    .sr_we_o(we), .sr_se_o(se), .sr_shift_in_o(sin), .sr_data_o(sdata),
    .inflight_o(inflight), .mispred_cnt_o(mcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // the history shift register the controller drives
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ghr <= '0;
    else if (we)  ghr <= sdata;
    else if (se)  ghr <= {ghr[HL-2:0], sin};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rest = 0;
    m_rval = '0;
    m_ghr  = '0;
    m_wr   = 0;
    m_cnt  = '0;
  endtask

  // compare all outputs against the model, then advance the model one cycle
  task automatic check_and_step();
    bit            exp_ready, acc, exp_we;
    logic [HL-1:0] g_old;
    logic [31:0]   exp_cnt;
    exp_ready = !m_rest && (m_q.size() < NC) && !flush && !(rv && rm);
    acc       = pv && exp_ready;
    exp_we    = m_rest && !flush;
`ifdef GHR_MISPRED_CNT_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 32'd0;
`endif
    chk("ready",    32'(ready),    32'(exp_ready));
    chk("se",       32'(se),       32'(acc));
    chk("shift_in", 32'(sin),      32'(acc && pt));
    chk("we",       32'(we),       32'(exp_we));
    chk("we_se_excl", 32'(we && se), 32'd0);
    chk("data",     32'(sdata),    32'(m_rval));
    chk("tag",      32'(tag),      32'(m_wr));
    chk("inflight", 32'(inflight), 32'(m_q.size()));
    chk("ghr",      32'(ghr),      32'(m_ghr));
    chk("mcnt",     mcnt,          exp_cnt);

    g_old = m_ghr;
    if (exp_we)   m_ghr = m_rval;
    else if (acc) m_ghr = {m_ghr[HL-2:0], pt};

    if (flush) begin
      m_q.delete(); m_wr = 0; m_rest = 0;
    end else if (m_rest) begin
      m_rest = 0;
    end else if (rv && rm && m_q.size() > 0) begin
      m_rval = {m_q[0][HL-2:0], rt};
      m_q.delete(); m_wr = 0; m_rest = 1;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end else begin
      if (rv && !rm && m_q.size() > 0) void'(m_q.pop_front());
      if (acc) begin
        m_q.push_back(g_old);
        m_wr = (m_wr + 1) % NC;
      end
    end
  endtask

  task automatic cycle(input bit f, input bit p_v, input bit p_t,
                       input bit r_v, input bit r_m, input bit r_t);
    @(negedge clk);
    flush = f; pv = p_v; pt = p_t; rv = r_v; rm = r_m; rt = r_t;
    #1;
    check_and_step();
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [HL-1:0] saved;
    rst_n = 1'b0; flush = 0; pv = 0; pt = 0; rv = 0; rm = 0; rt = 0;
    model_reset();
    #3;
    chk("rst_we",       32'(we),       32'd0);
    chk("rst_se",       32'(se),       32'd0);
    chk("rst_data",     32'(sdata),    32'd0);
    chk("rst_tag",      32'(tag),      32'd0);
    chk("rst_inflight", 32'(inflight), 32'd0);
    chk("rst_mcnt",     mcnt,          32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // T, N, T from ghr=0
    cycle(0, 1, 1, 0, 0, 0); chk("lit_tag0", 32'(tag), 32'd0);
    cycle(0, 1, 0, 0, 0, 0); chk("lit_tag1", 32'(tag), 32'd1);
    cycle(0, 1, 1, 0, 0, 0); chk("lit_tag2", 32'(tag), 32'd2);
    idle();
    chk("lit_ghr_101", 32'(ghr), 32'h05);
    chk("lit_inflight3", 32'(inflight), 32'd3);

    // mispredict on checkpoints {00,01,02} with actual taken
    cycle(0, 1, 0, 1, 1, 1); chk("lit_mis_ready", 32'(ready), 32'd0);
    idle();
    chk("lit_restore_we", 32'(we), 32'd1);
    chk("lit_restore_data", 32'(sdata), 32'h01);
    chk("lit_restore_inflight", 32'(inflight), 32'd0);
    chk("lit_restore_ready", 32'(ready), 32'd0);
    idle();
    chk("lit_post_ready", 32'(ready), 32'd1);
    chk("lit_post_ghr", 32'(ghr), 32'h01);

    // fill, then predict + correct resolve while full
    for (int i = 0; i < NC; i++) cycle(0, 1, 1'($urandom_range(0, 1)), 0, 0, 0);
    idle();
    chk("lit_full_inflight", 32'(inflight), 32'd4);
    cycle(0, 1, 1, 1, 0, 0);
    chk("lit_full_ready", 32'(ready), 32'd0);
    idle();
    chk("lit_after_pop_inflight", 32'(inflight), 32'd3);
    chk("lit_after_pop_ready", 32'(ready), 32'd1);

    // flush, then push/pop at inflight 2 across the pointer wrap
    cycle(1, 1, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 1, 1, 1, 0, 0); chk("lit_tag3", 32'(tag), 32'd3);
    chk("lit_pp_inflight_a", 32'(inflight), 32'd2);
    cycle(0, 1, 0, 1, 0, 0); chk("lit_tag_wrap", 32'(tag), 32'd0);
    idle();
    chk("lit_pp_inflight_b", 32'(inflight), 32'd2);

    // flush during the RESTORE cycle
    cycle(0, 0, 0, 1, 1, 0);
    saved = m_ghr;
    cycle(1, 0, 0, 0, 0, 0);
    chk("lit_flush_we", 32'(we), 32'd0);
    idle();
    chk("lit_flush_inflight", 32'(inflight), 32'd0);
    chk("lit_flush_ready", 32'(ready), 32'd1);
    chk("lit_flush_ghr", 32'(ghr), 32'(saved));

    // resolve with empty FIFO
    cycle(0, 0, 0, 1, 1, 1);
    idle();
    chk("lit_empty_res_we", 32'(we), 32'd0);

    // reset asserted mid-RESTORE
    cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 0);
    idle();
    rst_n = 1'b0;
    #1;
    chk("lit_async_we", 32'(we), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // five mispredicts
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 1, 0, 0, 0);
      cycle(0, 0, 0, 1, 1, 1);
      idle();
    end
`ifdef GHR_MISPRED_CNT_EN
    chk("lit_mcnt5", mcnt, 32'd5);
`else
    chk("lit_mcnt0", mcnt, 32'd0);
`endif

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit f, v, t, r, m, a;
      f = ($urandom_range(0, 99) < 3);
      v = ($urandom_range(0, 99) < 60);
      t = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 99) < 40);
      m = ($urandom_range(0, 99) < 25);
      a = 1'($urandom_range(0, 1));
      cycle(f, v, t, r, m, a);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ghr_ckpt_ctrl.md
Name: ghr_ckpt_ctrl

Overview:
- Sequences the perceptron predictor's global-history shift register.
- Issues a speculative shift on each accepted prediction and keeps a FIFO of pre-shift history checkpoints, one per in-flight branch.
- Resolves branches in order; on a mispredict, rebuilds the history from the oldest checkpoint plus the actual outcome and writes it back in parallel.
- Sits between the frontend predict stage, the branch-resolve path and the shift register's we/se/shift_in/data_in controls.

Parameters:
- HIST_LEN, 32, shift register width in bits.
- NUM_CKPT, 8, checkpoint FIFO depth; power of 2, at least 2.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous reset, active-low.
- flush_i  in  1  pipeline flush; drops all checkpoints.
- pred_valid_i  in  1  a prediction wants a history slot.
- pred_taken_i  in  1  predicted direction.
- pred_ready_o  out  1  prediction accepted this cycle when high together with pred_valid_i.
- pred_tag_o  out  $clog2(NUM_CKPT)  FIFO slot assigned to the accepted prediction.
- res_valid_i  in  1  resolution of the oldest in-flight branch.
- res_mispredict_i  in  1  that branch was mispredicted.
- res_taken_i  in  1  actual direction of that branch.
- ghr_i  in  HIST_LEN  current shift register output.
- sr_we_o  out  1  parallel-load strobe to the shift register.
- sr_se_o  out  1  shift-enable strobe to the shift register.
- sr_shift_in_o  out  1  bit shifted in.
- sr_data_o  out  HIST_LEN  parallel-load value.
- inflight_o  out  $clog2(NUM_CKPT)+1  number of occupied checkpoints.
- mispred_cnt_o  out  32  mispredict counter (see Optional Feature).

Behaviour:
- Reset (asynchronous, rst_ni low):
  - state=RUN; FIFO empty (read/write pointers 0, inflight_o=0).
  - sr_we_o=0, sr_se_o=0, sr_data_o=0, pred_tag_o=0, mispred_cnt_o=0.
  - pred_ready_o=1 once rst_ni is released.
- FSM states: RUN, RESTORE.
  - RUN -> RESTORE: res_valid_i && res_mispredict_i && FIFO not empty && !flush_i.
  - RESTORE -> RUN: unconditionally after 1 cycle.
- Accept condition, pred_ready_o (combinational): state==RUN && !full && !flush_i && !(res_valid_i && res_mispredict_i).
- Accepted prediction (pred_valid_i && pred_ready_o):
  - Push ghr_i (pre-shift value) into FIFO slot wr_ptr; pred_tag_o=wr_ptr.
  - sr_se_o=1 and sr_shift_in_o=pred_taken_i in the same cycle, so the shift register updates at that edge.
  - sr_shift_in_o=0 whenever sr_se_o=0.
- Correct resolution (res_valid_i && !res_mispredict_i, FIFO not empty): pop the oldest checkpoint. History is unchanged.
- Mispredict (res_valid_i && res_mispredict_i, FIFO not empty):
  - Register restore value = {ckpt[rd_ptr][HIST_LEN-2:0], res_taken_i}.
  - Clear the whole FIFO; younger branches are squashed by the frontend.
  - Go to RESTORE.
- RESTORE cycle:
  - sr_we_o=1, sr_data_o=restore value, sr_se_o=0, pred_ready_o=0.
  - New history is visible on ghr_i in the following cycle.
  - Restore latency: resolve cycle + 1; the first new prediction can be accepted 2 cycles after the mispredict.
- Simultaneous accepted predict and correct resolve: push and pop in the same cycle; inflight_o unchanged.
- Full FIFO (inflight_o==NUM_CKPT): pred_ready_o=0 even if a pop occurs in the same cycle. No bypass.
- Resolve with empty FIFO: ignored; no pop, no state change, no count change.
- Pointer wrap-around: pointers wrap modulo NUM_CKPT. Full/empty is decided by inflight_o, not by pointer compare.
- flush_i has highest priority:
  - FIFO cleared, state->RUN, sr_we_o=0 and sr_se_o=0 that cycle.
  - A pending RESTORE is cancelled and any resolve that cycle is ignored.
  - The history register itself is not modified.
- Reset asserted mid-RESTORE: state returns to RUN; sr_we_o drops immediately (asynchronous).
- sr_we_o and sr_se_o are never both 1 in any cycle.

Optional Feature:
- Macro GHR_MISPRED_CNT_EN.
- Defined: mispred_cnt_o increments by 1 on each mispredict that enters RESTORE. It saturates at 32'hFFFF_FFFF, is cleared by reset only, and is not affected by flush_i.
- Not defined: the counter logic is absent and mispred_cnt_o is tied to 0.

Test Plan:
- Reset, then 3 accepted predictions T,N,T starting from ghr=0 (HIST_LEN=8) -> sr_se_o pulses 3 cycles; ghr ends 8'b00000101; pred_tag_o=0,1,2; inflight_o=3.
- Fill the FIFO with NUM_CKPT=4 predictions, then pred_valid_i held with a correct resolve in the same cycle -> pred_ready_o=0; inflight_o goes 4->3; ready returns the next cycle.
- Checkpoints {8'h00,8'h01,8'h02}, mispredict with res_taken_i=1 -> next cycle sr_we_o=1, sr_data_o=8'h01; inflight_o=0; pred_ready_o low for 2 cycles.
- Simultaneous accepted predict and correct resolve at inflight_o=2 -> inflight_o stays 2; pointer wrap from slot 3 to slot 0 verified.
- flush_i asserted in the RESTORE cycle -> sr_we_o=0; inflight_o=0; state RUN; ghr unchanged.
- With GHR_MISPRED_CNT_EN defined, 5 mispredicts -> mispred_cnt_o=5. Without the macro, mispred_cnt_o stays 0 for the same stimulus.
